// File: rtl/cspcng_stream_ctrl.sv
// Sequencing controller for the CS-PCNG coupled chaotic-map datapath: seeds it,
// discards a warm-up run, then streams 32-bit keystream words under backpressure.
module cspcng_stream_ctrl #(
  parameter int unsigned WARMUP        = 16,
  parameter int unsigned WORDS_PER_KEY = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [146:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         stop,
  output logic [31:0]  dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         key_err,
  output logic         done,
  output logic [146:0] ds_key,
  output logic [31:0]  ds_xp0,
  output logic [31:0]  ds_xs0,
  output logic         ds_s,
  output logic         ds_en1,
  output logic         ds_reset,
  input  logic [31:0]  ds_xpn,
  input  logic [31:0]  ds_xsn
);

  localparam int unsigned KW = 147;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WARM,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_warm;
  logic [CW-1:0] r_ldcnt;
  logic [CW-1:0] r_wcnt;
  logic [DW-1:0] r_hp;
  logic [DW-1:0] r_hs;
  logic [DW-1:0] r_dout;
  logic [KW-1:0] r_ds_key;
  logic          r_dout_valid;
  logic          r_key_ready;
  logic          r_key_err;
  logic          r_done;
  logic          r_ds_s;
  logic          r_ds_en1;
  logic          r_ds_reset;

  logic w_adv;
  logic w_accept;
  logic w_key_bad;

  assign w_adv     = !r_dout_valid || dout_ready;
  assign w_accept  = r_dout_valid && dout_ready;
  assign w_key_bad = (key_in[31:0] == '0) || (key_in[63:32] == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_warm       <= '0;
      r_ldcnt      <= '0;
      r_wcnt       <= '0;
      r_hp         <= '0;
      r_hs         <= '0;
      r_dout       <= '0;
      r_ds_key     <= '0;
      r_dout_valid <= 1'b0;
      r_key_ready  <= 1'b1;
      r_key_err    <= 1'b0;
      r_done       <= 1'b0;
      r_ds_s       <= 1'b0;
      r_ds_en1     <= 1'b0;
      r_ds_reset   <= 1'b1;
    end else begin
      r_key_err <= 1'b0;
      r_done    <= 1'b0;
      if (stop && (r_state != S_IDLE)) begin
        r_state      <= S_IDLE;
        r_dout_valid <= 1'b0;
        r_key_ready  <= 1'b1;
        r_ds_s       <= 1'b0;
        r_ds_en1     <= 1'b0;
        r_ds_reset   <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (key_valid) begin
              if (w_key_bad) begin
                r_key_err <= 1'b1;
              end else begin
                r_ds_key    <= key_in;
                r_hp        <= key_in[31:0];
                r_hs        <= key_in[63:32];
                r_key_ready <= 1'b0;
                r_ds_en1    <= 1'b1;
                r_ds_reset  <= 1'b0;
                r_ds_s      <= 1'b0;
                r_state     <= S_SEED;
              end
            end
          end
          S_SEED: begin
            r_ds_s  <= 1'b1;
            r_warm  <= CW'(WARMUP);
            r_state <= S_WARM;
          end
          S_WARM: begin
            r_hp   <= ds_xpn;
            r_hs   <= ds_xsn;
            r_warm <= r_warm - CW'(1);
            if (r_warm == CW'(1)) begin
              r_ldcnt <= '0;
              r_wcnt  <= '0;
              r_ds_s  <= 1'b0;
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            if (w_accept) r_wcnt <= r_wcnt + CW'(1);
            // Hold regs only follow the datapath when a new word is taken.
            if (w_adv) begin
              r_dout       <= ds_xpn ^ ds_xsn;
              r_dout_valid <= 1'b1;
              r_hp         <= ds_xpn;
              r_hs         <= ds_xsn;
              r_ldcnt      <= r_ldcnt + CW'(1);
              if (r_ldcnt + CW'(1) == CW'(WORDS_PER_KEY)) r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (w_accept && (r_wcnt + CW'(1) == CW'(WORDS_PER_KEY))) begin
              r_wcnt       <= r_wcnt + CW'(1);
              r_done       <= 1'b1;
              r_dout_valid <= 1'b0;
              r_key_ready  <= 1'b1;
              r_ds_en1     <= 1'b0;
              r_ds_reset   <= 1'b1;
              r_state      <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // In RUN the advance/re-seed choice must track the same-cycle consumer handshake.
  assign ds_s       = (r_state == S_RUN) ? w_adv : r_ds_s;
  assign key_ready  = r_key_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign key_err    = r_key_err;
  assign done       = r_done;
  assign ds_key     = r_ds_key;
  assign ds_xp0     = r_hp;
  assign ds_xs0     = r_hs;
  assign ds_en1     = r_ds_en1;
  assign ds_reset   = r_ds_reset;

endmodule

// File: tb/tb_cspcng_stream_ctrl.sv
// Directed bench for cspcng_stream_ctrl: behavioural datapath plus golden keystream,
// covering latency, stalls, stop, async reset, key rejection and a minimal configuration.
module tb_cspcng_stream_ctrl;

  localparam logic [146:0] KEY  = {19'h5A5A5, 32'hC0FFEE11, 32'h13579BDF, 32'h20000000, 32'h40000000};
  localparam logic [146:0] KEY1 = {19'h12345, 32'h0BADF00D, 32'h2468ACE1, 32'h00000777, 32'h12345678};
  localparam int NW = 1024;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // main instance, default parameters
  logic [146:0] key_in = '0;
  logic         key_valid = 1'b0, stop = 1'b0, dout_ready = 1'b0;
  logic         key_ready, dout_valid, key_err, done, ds_s, ds_en1, ds_reset;
  logic [31:0]  dout, ds_xp0, ds_xs0;
  logic [146:0] ds_key;
  logic [31:0]  ds_xpn = '0, ds_xsn = '0;

  // minimal instance
  logic [146:0] key_in1 = '0;
  logic         key_valid1 = 1'b0, stop1 = 1'b0, dout_ready1 = 1'b0;
  logic         key_ready1, dout_valid1, key_err1, done1, ds_s1, ds_en11, ds_reset1;
  logic [31:0]  dout1, ds_xp01, ds_xs01;
  logic [146:0] ds_key1;
  logic [31:0]  ds_xpn1 = '0, ds_xsn1 = '0;

  cspcng_stream_ctrl dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .stop(stop), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .key_err(key_err), .done(done), .ds_key(ds_key), .ds_xp0(ds_xp0), .ds_xs0(ds_xs0),
    .ds_s(ds_s), .ds_en1(ds_en1), .ds_reset(ds_reset), .ds_xpn(ds_xpn), .ds_xsn(ds_xsn)
  );

  cspcng_stream_ctrl #(.WARMUP(1), .WORDS_PER_KEY(1)) dut1 (
    .clk(clk), .reset(reset), .key_in(key_in1), .key_valid(key_valid1), .key_ready(key_ready1),
    .stop(stop1), .dout(dout1), .dout_valid(dout_valid1), .dout_ready(dout_ready1),
    .key_err(key_err1), .done(done1), .ds_key(ds_key1), .ds_xp0(ds_xp01), .ds_xs0(ds_xs01),
    .ds_s(ds_s1), .ds_en1(ds_en11), .ds_reset(ds_reset1), .ds_xpn(ds_xpn1), .ds_xsn(ds_xsn1)
  );

  // Stand-in for the coupled-map iteration F(xp, xs; key)
  function automatic logic [63:0] f_map(input logic [31:0] xp, input logic [31:0] xs,
                                        input logic [146:0] k);
    logic [31:0] a, b;
    a = ((xp ^ (xs >> 3)) * 32'h9E3779B1) + k[95:64];
    b = {xs[26:0], xs[31:27]} ^ xp ^ k[127:96] ^ {13'd0, k[146:128]};
    return {a, b};
  endfunction

  always @(posedge clk) begin
    if (ds_reset) begin
      ds_xpn <= '0; ds_xsn <= '0;
    end else if (ds_en1) begin
      if (ds_s) {ds_xpn, ds_xsn} <= f_map(ds_xpn, ds_xsn, ds_key);
      else      {ds_xpn, ds_xsn} <= f_map(ds_xp0, ds_xs0, ds_key);
    end
  end

  always @(posedge clk) begin
    if (ds_reset1) begin
      ds_xpn1 <= '0; ds_xsn1 <= '0;
    end else if (ds_en11) begin
      if (ds_s1) {ds_xpn1, ds_xsn1} <= f_map(ds_xpn1, ds_xsn1, ds_key1);
      else       {ds_xpn1, ds_xsn1} <= f_map(ds_xp01, ds_xs01, ds_key1);
    end
  end

  int n_chk = 0, n_pass = 0;
  int n_done = 0, n_both = 0;
  logic [31:0] gold [NW];

  always @(negedge clk) begin
    if (done) n_done++;
    if (done && key_err) n_both++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] gold_word(input logic [146:0] k, input int n_iter);
    logic [63:0] st;
    st = {k[31:0], k[63:32]};
    for (int i = 0; i < n_iter; i++) st = f_map(st[63:32], st[31:0], k);
    return st[63:32] ^ st[31:0];
  endfunction

  // Caller sits at a negedge; returns at the negedge after the accepting edge.
  task automatic send_key(input logic [146:0] k, input logic with_stop);
    key_in = k; key_valid = 1'b1; stop = with_stop;
    @(negedge clk);
    key_valid = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_first(output int lat);
    lat = 0;
    while (!dout_valid && lat < 100) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic take_words(input int n, input bit rnd);
    int got = 0, cyc = 0;
    bit stalled = 1'b0;
    logic [31:0] held = '0;
    while (got < n && cyc < 20000) begin
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) chk("stall_hold", {31'd0, dout_valid, dout}, {31'd0, 1'b1, held});
      stalled = 1'b0;
      if (dout_valid) begin
        if (dout_ready) begin
          chk($sformatf("word%0d", got), 64'(dout), 64'(gold[got]));
          got++;
        end else begin
          stalled = 1'b1; held = dout;
        end
      end
      @(negedge clk); cyc++;
    end
    if (got < n) chk("take_timeout", 64'(got), 64'(n));
  endtask

  initial begin
    int lat, d0;
    logic [63:0] st;
    st = f_map(KEY[31:0], KEY[63:32], KEY);
    for (int i = 0; i < 16; i++) st = f_map(st[63:32], st[31:0], KEY);
    for (int i = 0; i < NW; i++) begin
      gold[i] = st[63:32] ^ st[31:0];
      st = f_map(st[63:32], st[31:0], KEY);
    end

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_dout", dout, 32'd0);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_ds_en1", ds_en1, 1'b0);
    chk("rst_ds_reset", ds_reset, 1'b1);
    chk("rst_ds_s", ds_s, 1'b0);
    chk("rst_ds_key", ds_key, 147'd0);
    chk("rst_ds_xp0", {ds_xp0, ds_xs0}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // key rejection: Xp zero, then Xs zero
    send_key({KEY[146:32], 32'd0}, 1'b0);
    chk("kerr_pulse", key_err, 1'b1);
    chk("kerr_ready", key_ready, 1'b1);
    chk("kerr_en1", ds_en1, 1'b0);
    chk("kerr_dskey", ds_key, 147'd0);
    @(negedge clk);
    chk("kerr_width", key_err, 1'b0);
    send_key({KEY[146:64], 32'd0, KEY[31:0]}, 1'b0);
    chk("kerr_xs_pulse", key_err, 1'b1);
    @(negedge clk);
    chk("kerr_xs_idle", {key_err, key_ready, ds_en1}, 3'b010);

    // nominal stream, consumer always ready
    dout_ready = 1'b1;
    d0 = n_done;
    send_key(KEY, 1'b0);
    chk("seed_s", ds_s, 1'b0);
    chk("seed_en", {ds_en1, ds_reset, key_ready}, 3'b100);
    chk("seed_x0", {ds_xp0, ds_xs0}, {32'h40000000, 32'h20000000});
    chk("seed_key", ds_key, KEY);
    wait_first(lat);
    chk("latency", 64'(lat), 64'd18);
    take_words(NW, 1'b0);
    chk("done_pulse", done, 1'b1);
    chk("done_ready", key_ready, 1'b1);
    chk("done_valid", dout_valid, 1'b0);
    @(negedge clk);
    chk("done_width", done, 1'b0);
    chk("done_count", 64'(n_done - d0), 64'd1);

    // same key, random backpressure
    d0 = n_done;
    send_key(KEY, 1'b0);
    wait_first(lat);
    chk("latency_rnd", 64'(lat), 64'd18);
    take_words(NW, 1'b1);
    dout_ready = 1'b0;
    chk("done_rnd", done, 1'b1);
    @(negedge clk);
    chk("done_rnd_count", 64'(n_done - d0), 64'd1);

    // stop during warm-up
    d0 = n_done;
    send_key(KEY, 1'b0);
    @(negedge clk);
    chk("warm_s", ds_s, 1'b1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stopw_state", {key_ready, ds_en1, ds_reset, dout_valid}, 4'b1010);

    // stop at word 100, then restart (stop held in IDLE is ignored)
    send_key(KEY, 1'b0);
    wait_first(lat);
    take_words(100, 1'b0);
    dout_ready = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stopr_valid", dout_valid, 1'b0);
    chk("stopr_ready", key_ready, 1'b1);
    send_key(KEY, 1'b1);
    chk("idle_stop_accept", key_ready, 1'b0);
    wait_first(lat);
    chk("latency_restart", 64'(lat), 64'd18);
    take_words(100, 1'b0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    chk("stop_no_done", 64'(n_done - d0), 64'd0);

    // async reset at word 500
    send_key(KEY, 1'b0);
    wait_first(lat);
    take_words(500, 1'b0);
    dout_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_valid", dout_valid, 1'b0);
    chk("arst_dout", dout, 32'd0);
    chk("arst_ctl", {key_ready, ds_en1, ds_reset, ds_s}, 4'b1010);
    chk("arst_key", ds_key, 147'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_key(KEY, 1'b0);
    wait_first(lat);
    chk("latency_post_rst", 64'(lat), 64'd18);
    take_words(20, 1'b0);
    dout_ready = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // WARMUP=1, WORDS_PER_KEY=1
    key_in1 = KEY1; key_valid1 = 1'b1;
    @(negedge clk);
    key_valid1 = 1'b0;
    lat = 0;
    while (!dout_valid1 && lat < 100) begin
      @(negedge clk); lat++;
    end
    chk("min_latency", 64'(lat), 64'd3);
    chk("min_word", dout1, gold_word(KEY1, 2));
    @(negedge clk);
    chk("min_hold", {dout_valid1, dout1}, {1'b1, gold_word(KEY1, 2)});
    chk("min_no_done", done1, 1'b0);
    dout_ready1 = 1'b1;
    @(negedge clk);
    chk("min_done", {done1, dout_valid1, key_ready1}, 3'b101);
    @(negedge clk);
    chk("min_after", {done1, dout_valid1, key_ready1}, 3'b001);
    dout_ready1 = 1'b0;

    chk("done_and_kerr", 64'(n_both), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cspcng_stream_ctrl.md
# cspcng_stream_ctrl

Sequencing controller for the coupled chaotic-map internal-state datapath (the PWLCM/skew-tent pair with coupling weights e11..e22) in the CS-PCNG. Accepts a 147-bit key/seed by valid/ready handshake and drives the datapath's `s`/`en1`/`reset`/seed inputs. Discards a warm-up run, then emits 32-bit keystream words under valid/ready backpressure. Consumer stalls are absorbed by re-seeding the datapath from a held predecessor state, so the chaotic trajectory is never lost and the datapath never sees `en1=0` mid-stream.

## Interface
- `WARMUP`, 16: discarded iterations after seeding; ≥1.
- `WORDS_PER_KEY`, 1024: words emitted per key before returning to idle; ≥1, ≤2^32−1.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `key_in` in 147: [31:0] Xp seed, [63:32] Xs seed, [146:64] map parameters/couplings.
- `key_valid` in 1, `key_ready` out 1: key handshake.
- `stop` in 1: abort current stream.
- `dout` out 32, `dout_valid` out 1, `dout_ready` in 1: keystream word handshake.
- `key_err` out 1: one-cycle pulse when a key is rejected.
- `done` out 1: one-cycle pulse after the last word of a key is accepted.
- `ds_key` out 147, `ds_xp0` out 32, `ds_xs0` out 32, `ds_s` out 1, `ds_en1` out 1, `ds_reset` out 1: to datapath.
- `ds_xpn` in 32, `ds_xsn` in 32: datapath state. The datapath updates on every `clk` edge with `en1=1`, with one-cycle latency.

## Operation
- States: IDLE, SEED, WARM, RUN, DRAIN.
- IDLE
  - `key_ready=1`, `ds_reset=1`, `ds_en1=0`.
  - On `key_valid`: if `key_in[31:0]==0` or `key_in[63:32]==0`, pulse `key_err` and stay in IDLE.
  - Otherwise latch the key into `ds_key` and `hp/hs`, and go to SEED.
- Hold regs `hp/hs` (32b each) always contain the predecessor of the datapath's current state.
- Outside IDLE: `ds_reset=0`, `ds_en1=1`, `ds_xp0=hp`, `ds_xs0=hs`, `key_ready=0`.
- SEED (1 cycle): `ds_s=0`. The datapath loads F(seed). Go to WARM with warm counter = WARMUP.
- WARM
  - Each cycle: `ds_s=1`, `hp/hs <= ds_xpn/ds_xsn`, decrement the counter.
  - After WARMUP cycles, go to RUN with word counter = 0.
- RUN: `adv = !dout_valid || dout_ready`.
  - If `adv`: `ds_s=1`, `dout <= ds_xpn ^ ds_xsn`, `dout_valid <= 1`, `hp/hs <= ds_xpn/ds_xsn`.
  - If `!adv`: `ds_s=0`. The datapath recomputes F(hp,hs), so its state is unchanged.
  - Word counter increments on each accepted word (`dout_valid && dout_ready`).
  - After WORDS_PER_KEY words have been loaded into `dout`, stop advancing and go to DRAIN.
- DRAIN
  - `ds_s=0`.
  - When the final word is accepted: pulse `done`, clear `dout_valid`, go to IDLE.
- `stop` in any non-IDLE state: next edge goes to IDLE, `dout_valid` clears, no `done` pulse. `stop` has priority over every other transition.
- `stop` in IDLE is ignored; a simultaneous `key_valid` is still processed.

## Timing
- Reset values: state IDLE, `key_ready=1`, `dout=0`, `dout_valid=0`, `key_err=0`, `done=0`, `ds_key=0`, `ds_xp0=0`, `ds_xs0=0`, `ds_s=0`, `ds_en1=0`, `ds_reset=1`, all counters 0.
- Key accepted at edge E0:
  - SEED occupies the cycle after E0.
  - WARM occupies edges E1..E(WARMUP+1).
  - First `dout_valid` rises at E(WARMUP+2), i.e. 18 cycles with defaults.
- Throughput: one word per cycle while `dout_ready=1`.
- Backpressure:
  - `dout`/`dout_valid` are stable while `dout_valid && !dout_ready`.
  - No word is skipped or duplicated.
- `reset` asserted mid-stream: all outputs take their reset values immediately (asynchronous). Deassertion is synchronous to `clk`.
- `key_err` and `done` are exactly one cycle wide. They never assert in the same cycle.

## Test plan
- Key with Xp=0x40000000, Xs=0x20000000, defaults, `dout_ready=1` constant → first `dout_valid` 18 cycles after key accept; 1024 consecutive words matching the golden model; `done` pulses once; `key_ready` high again the next cycle.
- Same key, `dout_ready` random 50% → word sequence identical to the no-stall run; `dout` held constant through every stall cycle.
- `key_in[31:0]=0` → `key_err` 1-cycle pulse, state stays IDLE, `ds_en1` stays 0; a following valid key is accepted normally.
- `stop` asserted in WARM and again at word 100 of RUN → IDLE next edge, `dout_valid=0`, no `done`; restarting with the same key reproduces the same first 100 words.
- `reset` low for 1 cycle at word 500 → outputs at reset values; fresh key yields the sequence from word 0.
- WARMUP=1, WORDS_PER_KEY=1 → `dout_valid` 3 cycles after key accept; exactly one word; `done` on its acceptance.
